song_memory_axi4_v2: RTL and testbench

- Parametrised AXI4 (full) slave memory holding song/sample data.
- Written and read back by the PS or an AXI master over one port.
- Successor to the fixed 32-bit, INCR-only song memory. Adds:
  - configurable data width and depth;
  - FIXED, INCR and WRAP bursts;
  - byte strobes;
  - SLVERR on out-of-range beats;
  - independent, concurrently active read and write channels.

---
 rtl/song_memory_axi4_v2.sv | 221 ++++++++++++++++++++++
 tb/tb_song_memory_axi4_v2.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_memory_axi4_v2.sv
// AXI4 slave memory for song/sample data: FIXED/INCR/WRAP bursts, byte strobes,
// SLVERR on out-of-range beats, independent read and write channels.
module song_memory_axi4_v2 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH          = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic [1:0]                        s_axi_awburst,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    input  logic [1:0]                        s_axi_arburst,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rlast,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready
);
    localparam int BPB = C_S_AXI_DATA_WIDTH / 8;
    localparam int LSB = $clog2(BPB);
    localparam int IW  = $clog2(MEM_DEPTH);
    // Extra headroom so a burst running past the top of the map never aliases back to 0.
    localparam int XAW = C_S_AXI_ADDR_WIDTH + 12;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [XAW-1:0] xaddr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic xaddr_t next_addr(input xaddr_t addr, input logic [1:0] burst, input logic [7:0] len);
        xaddr_t inc;
        xaddr_t mask;
        inc  = addr + xaddr_t'(BPB);
        mask = ((xaddr_t'(len) + xaddr_t'(1)) << LSB) - xaddr_t'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    function automatic logic in_range(input xaddr_t addr);
        return (addr >> LSB) < xaddr_t'(MEM_DEPTH);
    endfunction

    function automatic xaddr_t align(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        return xaddr_t'(addr) & ~xaddr_t'(BPB - 1);
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q;

    // ---------------- write channel ----------------
    w_state_t   w_state, w_state_nxt;
    xaddr_t     w_addr;
    logic [7:0] w_len, w_cnt;
    logic [1:0] w_burst;
    logic       w_err, aw_hs, w_hs, w_last_beat, w_beat_err, w_we;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = !in_range(w_addr) || (s_axi_wlast != w_last_beat);
    assign w_we        = w_hs && in_range(w_addr);

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= BURST_INCR;
            w_err         <= 1'b0;
        end else begin
            w_state       <= w_state_nxt;
            s_axi_awready <= (w_state_nxt == W_IDLE);
            s_axi_wready  <= (w_state_nxt == W_DATA);
            s_axi_bvalid  <= (w_state_nxt == W_RESP);
            if (aw_hs) begin
                w_addr  <= align(s_axi_awaddr);
                w_len   <= s_axi_awlen;
                w_burst <= burst_illegal(s_axi_awburst, s_axi_awlen) ? BURST_INCR : s_axi_awburst;
                w_err   <= burst_illegal(s_axi_awburst, s_axi_awlen);
                w_cnt   <= '0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_burst, w_len);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err | w_beat_err;
                if (w_last_beat)
                    s_axi_bresp <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ---------------- read channel ----------------
    // Two-stage pipe: stage 1 is the registered RAM read, stage 2 the R output register.
    r_state_t   r_state, r_state_nxt;
    xaddr_t     r_addr;
    logic [7:0] r_len, r_cnt;
    logic [1:0] r_burst;
    logic       r_err, r_issued_all, ar_hs, r_done;
    logic       s1_valid, s1_oor, s1_err, s1_last, s1_adv, s2_adv, r_issue;

    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign r_done  = s_axi_rvalid && s_axi_rready && s_axi_rlast;
    assign s2_adv  = !s_axi_rvalid || s_axi_rready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign r_issue = (r_state == R_DATA) && !r_issued_all && s1_adv;

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_done) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= BURST_INCR;
            r_err         <= 1'b0;
            r_issued_all  <= 1'b0;
            s1_valid      <= 1'b0;
            s1_oor        <= 1'b0;
            s1_err        <= 1'b0;
            s1_last       <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            r_state       <= r_state_nxt;
            s_axi_arready <= (r_state_nxt == R_IDLE);
            if (ar_hs) begin
                r_addr       <= align(s_axi_araddr);
                r_len        <= s_axi_arlen;
                r_burst      <= burst_illegal(s_axi_arburst, s_axi_arlen) ? BURST_INCR : s_axi_arburst;
                r_err        <= burst_illegal(s_axi_arburst, s_axi_arlen);
                r_cnt        <= '0;
                r_issued_all <= 1'b0;
            end
            if (r_issue) begin
                r_addr <= next_addr(r_addr, r_burst, r_len);
                r_cnt  <= r_cnt + 8'd1;
                if (r_cnt == r_len) r_issued_all <= 1'b1;
            end
            if (s1_adv) begin
                s1_valid <= r_issue;
                s1_oor   <= !in_range(r_addr);
                s1_err   <= r_err || !in_range(r_addr);
                s1_last  <= (r_cnt == r_len);
            end
            if (s2_adv) begin
                s_axi_rvalid <= s1_valid;
                s_axi_rlast  <= s1_valid && s1_last;
                if (s1_valid) begin
                    s_axi_rdata <= s1_oor ? '0 : mem_q;
                    s_axi_rresp <= s1_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // NOTE: the RAM array and its read register are deliberately not reset so they map onto block RAM.
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < BPB; b++)
            if (w_we && s_axi_wstrb[b])
                mem[w_addr[LSB +: IW]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        if (r_issue)
            mem_q <= mem[r_addr[LSB +: IW]];
    end

endmodule

// File: tb/tb_song_memory_axi4_v2.sv
// Scoreboard bench for song_memory_axi4_v2: drivers push expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_song_memory_axi4_v2;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [11:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [1:0]  s_axi_awburst, s_axi_arburst;
    logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    song_memory_axi4_v2 dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    r_exp_t      exp_r[$];
    logic [1:0]  exp_b[$];
    logic [31:0] wbuf[16];
    int          checks = 0;
    int          failures = 0;
    int          r_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return s_axi_awready;
            1:       return s_axi_wready;
            default: return s_axi_arready;
        endcase
    endfunction

    // Waits (bounded) until the channel's ready is seen with valid high, then
    // steps past the handshaking edge.
    task automatic wait_ready(input int ch, input string name);
        int t = 0;
        do begin
            @(negedge ACLK);
            t++;
        end while (!rdy(ch) && t < 100);
        if (!rdy(ch)) timeout(name);
        tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    r_exp_t      er;
    logic [1:0]  eb;
    logic        stalled = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    logic        held_last;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected actual=bresp_%0h expected=none", s_axi_bresp);
                end else begin
                    eb = exp_b.pop_front();
                    check("bresp", {62'd0, s_axi_bresp}, {62'd0, eb});
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected actual=rdata_%0h expected=none", s_axi_rdata);
                end else begin
                    er = exp_r.pop_front();
                    check("rdata", {32'd0, s_axi_rdata}, {32'd0, er.data});
                    check("rresp", {62'd0, s_axi_rresp}, {62'd0, er.resp});
                    check("rlast", {63'd0, s_axi_rlast}, {63'd0, er.last});
                end
                r_seen++;
            end
            if (s_axi_rvalid && !s_axi_rready) begin
                if (stalled)
                    check("r_hold", {29'd0, s_axi_rdata, s_axi_rresp, s_axi_rlast},
                          {29'd0, held_data, held_resp, held_last});
                held_data = s_axi_rdata;
                held_resp = s_axi_rresp;
                held_last = s_axi_rlast;
                stalled   = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic write_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [3:0] strb, input int wlast_beat, input logic [1:0] resp);
        int t = 0;
        exp_b.push_back(resp);
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        wait_ready(0, "aw_wait");
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata  = wbuf[i];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == wlast_beat);
            s_axi_wvalid = 1'b1;
            wait_ready(1, "w_wait");
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        while (exp_b.size() != 0 && t < 100) begin
            @(posedge ACLK);
            t++;
        end
        #1;
        if (exp_b.size() != 0) begin
            timeout("b_wait");
            exp_b.delete();
        end
    endtask

    task automatic exp_rd(input logic [31:0] data, input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic read_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input int stall_at, input int stall_len);
        int t = 0;
        int left = stall_len;
        r_seen        = 0;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        wait_ready(2, "ar_wait");
        s_axi_arvalid = 1'b0;
        while (r_seen < int'(len) + 1 && t < 300) begin
            if (r_seen == stall_at && left > 0) begin
                s_axi_rready = 1'b0;
                left--;
            end else begin
                s_axi_rready = 1'b1;
            end
            tick();
            t++;
        end
        s_axi_rready = 1'b1;
        if (r_seen < int'(len) + 1) begin
            timeout("r_wait");
            exp_r.delete();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ARESETN       = 1'b0;
        s_axi_awaddr  = '0; s_axi_awlen = '0; s_axi_awburst = INCR; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0; s_axi_arlen = '0; s_axi_arburst = INCR; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        tick(); tick();
        check("rst_awready", {63'd0, s_axi_awready}, 64'd0);
        check("rst_wready",  {63'd0, s_axi_wready},  64'd0);
        check("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        check("rst_arready", {63'd0, s_axi_arready}, 64'd0);
        check("rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
        check("rst_rlast",   {63'd0, s_axi_rlast},   64'd0);
        check("rst_resps",   {60'd0, s_axi_bresp, s_axi_rresp}, 64'd0);
        check("rst_rdata",   {32'd0, s_axi_rdata},   64'd0);
        ARESETN = 1'b1;
        tick();
        check("idle_ready", {62'd0, s_axi_awready, s_axi_arready}, 64'd3);

        // 1: INCR len 7 write and readback
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        write_burst(12'h000, 8'd7, INCR, 4'hF, 7, OKAY);
        for (int i = 0; i < 8; i++) exp_rd(32'(i + 1), OKAY, i == 7);
        read_burst(12'h000, 8'd7, INCR, -1, 0);

        // 2: WRAP len 3 from 0x008 lands A,B at 0x8/0xC and C,D at 0x0/0x4
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        write_burst(12'h008, 8'd3, WRAP, 4'hF, 3, OKAY);
        exp_rd(32'hC, OKAY, 1'b0); exp_rd(32'hD, OKAY, 1'b0);
        exp_rd(32'hA, OKAY, 1'b0); exp_rd(32'hB, OKAY, 1'b1);
        read_burst(12'h000, 8'd3, INCR, -1, 0);

        // 3: byte strobes on word 0x20
        wbuf[0] = 32'h12345678;
        write_burst(12'h080, 8'd0, INCR, 4'hF, 0, OKAY);
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(12'h080, 8'd0, INCR, 4'h3, 0, OKAY);
        exp_rd(32'h1234FFFF, OKAY, 1'b1);
        read_burst(12'h080, 8'd0, INCR, -1, 0);

        // 4: FIXED burst keeps hitting 0x010; 0x014/0x018 keep 6 and 7 from test 1
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(12'h010, 8'd3, FIXED, 4'hF, 3, OKAY);
        exp_rd(32'd4, OKAY, 1'b0); exp_rd(32'd4, OKAY, 1'b1);
        read_burst(12'h010, 8'd1, FIXED, -1, 0);
        exp_rd(32'd6, OKAY, 1'b0); exp_rd(32'd7, OKAY, 1'b1);
        read_burst(12'h014, 8'd1, INCR, -1, 0);

        // 5: burst running off the top of memory; 0x000 must keep 0xC
        wbuf[0] = 32'h55AA55AA; wbuf[1] = 32'h11111111;
        write_burst(12'hFFC, 8'd1, INCR, 4'hF, 1, SLVERR);
        exp_rd(32'h55AA55AA, OKAY, 1'b0); exp_rd(32'h0, SLVERR, 1'b1);
        read_burst(12'hFFC, 8'd1, INCR, -1, 0);
        exp_rd(32'hC, OKAY, 1'b1);
        read_burst(12'h000, 8'd0, INCR, -1, 0);

        // illegal WRAP length: treated as INCR with SLVERR
        wbuf[0] = 32'h101; wbuf[1] = 32'h202; wbuf[2] = 32'h303;
        write_burst(12'h200, 8'd2, WRAP, 4'hF, 2, SLVERR);
        exp_rd(32'h101, OKAY, 1'b0); exp_rd(32'h202, OKAY, 1'b0); exp_rd(32'h303, OKAY, 1'b1);
        read_burst(12'h200, 8'd2, INCR, -1, 0);
        // reserved burst type on read, and misplaced wlast on write
        exp_rd(32'hC, SLVERR, 1'b1);
        read_burst(12'h000, 8'd0, 2'b11, -1, 0);
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        write_burst(12'h300, 8'd1, INCR, 4'hF, 0, SLVERR);

        // 6a: rready low for 3 cycles once the 4th beat is presented
        exp_rd(32'hC, OKAY, 1'b0); exp_rd(32'hD, OKAY, 1'b0);
        exp_rd(32'hA, OKAY, 1'b0); exp_rd(32'hB, OKAY, 1'b0);
        exp_rd(32'd4, OKAY, 1'b0); exp_rd(32'd6, OKAY, 1'b0);
        exp_rd(32'd7, OKAY, 1'b0); exp_rd(32'd8, OKAY, 1'b1);
        read_burst(12'h000, 8'd7, INCR, 3, 3);

        // 6b: reset during beat 3 of a write
        s_axi_awaddr = 12'h040; s_axi_awlen = 8'd7; s_axi_awburst = INCR; s_axi_awvalid = 1'b1;
        wait_ready(0, "aw_wait_rst");
        s_axi_awvalid = 1'b0;
        s_axi_wstrb   = 4'hF;
        s_axi_wlast   = 1'b0;
        s_axi_wdata   = 32'h40404040; s_axi_wvalid = 1'b1;
        wait_ready(1, "w_wait_rst");
        s_axi_wdata   = 32'h44444444;
        wait_ready(1, "w_wait_rst");
        s_axi_wdata   = 32'h48484848;
        ARESETN       = 1'b0;
        tick();
        s_axi_wvalid  = 1'b0;
        check("midrst_bvalid", {63'd0, s_axi_bvalid}, 64'd0);
        tick();
        ARESETN = 1'b1;
        tick();
        check("post_rst_awready", {63'd0, s_axi_awready}, 64'd1);
        check("post_rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        repeat (5) tick();
        check("post_rst_no_b", {63'd0, s_axi_bvalid}, 64'd0);
        exp_rd(32'h40404040, OKAY, 1'b0); exp_rd(32'h44444444, OKAY, 1'b1);
        read_burst(12'h040, 8'd1, INCR, -1, 0);

        repeat (3) tick();
        check("b_queue_empty", 64'(exp_b.size()), 64'd0);
        check("r_queue_empty", 64'(exp_r.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
